// File: rtl/pc_ir_unit_pkg.sv
// Shared instruction-encoding constants for the fetch datapath and the control FSM.
package pc_ir_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_REG    = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6f
  } opcode_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_ir_unit_wrap_counter.sv
// Enabled up-counter that wraps from all-ones back to zero.
module wrap_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (en)
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/pc_ir_unit.sv
// Program counter and instruction register with captured return address and activity counters.
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_ir,
  input  logic               pc_update,
  input  logic               branch,
  input  logic               zero,
  input  logic               sel_pc_src,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        alu_reg,
  input  logic [31:0]        mem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        old_pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        instr,
  output logic [6:0]         op,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] cycle_cnt,
  output logic [COUNT_W-1:0] fetch_cnt
);

  logic        pc_we;
  logic [31:0] next_pc;
  logic [31:0] pc_inc;

  always_comb begin
    pc_we   = pc_update & (~branch | zero);
    next_pc = sel_pc_src ? alu_reg : alu_result;
    pc_inc  = pc + 32'd4;
  end

  assign op = instr[6:0];

  // IR capture samples the pre-edge pc, so a simultaneous PC write never leaks into old_pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      old_pc       <= RESET_PC;
      pc_plus4     <= RESET_PC + 32'd4;
      instr        <= NOP_INSTR;
      misalign_err <= 1'b0;
    end else begin
      if (pc_we) begin
        pc <= word_align(next_pc);
        if (next_pc[1:0] != 2'b00)
          misalign_err <= 1'b1;
      end
      if (we_ir) begin
        instr    <= mem_rdata;
        old_pc   <= pc;
        pc_plus4 <= pc_inc;
      end
    end
  end

  wrap_counter #(.WIDTH(COUNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (cycle_cnt)
  );

  wrap_counter #(.WIDTH(COUNT_W)) u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (we_ir),
    .count (fetch_cnt)
  );

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed vector table, random phase and reset/wrap sequences.
module tb_pc_ir_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_ir, pc_update, branch, zero, sel_pc_src;
  logic [31:0] alu_result, alu_reg, mem_rdata;
  logic [31:0] pc, old_pc, pc_plus4, instr;
  logic [6:0]  op;
  logic        misalign_err;
  logic [3:0]  cycle_cnt, fetch_cnt;

  pc_ir_unit #(.RESET_PC(RPC), .COUNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .we_ir        (we_ir),
    .pc_update    (pc_update),
    .branch       (branch),
    .zero         (zero),
    .sel_pc_src   (sel_pc_src),
    .alu_result   (alu_result),
    .alu_reg      (alu_reg),
    .mem_rdata    (mem_rdata),
    .pc           (pc),
    .old_pc       (old_pc),
    .pc_plus4     (pc_plus4),
    .instr        (instr),
    .op           (op),
    .misalign_err (misalign_err),
    .cycle_cnt    (cycle_cnt),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we, upd, br, z, sel;
    logic [31:0] ar, areg, mem;
    logic [31:0] e_pc, e_old, e_p4, e_instr;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc, old, p4, instr;
    logic        mis;
    int          cyc, fc;
  } exp_t;

  vec_t tbl[12];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] m_pc, m_old, m_p4, m_instr;
  logic        m_mis;
  int          m_cyc, m_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_old = RPC; m_p4 = RPC + 32'd4; m_instr = 32'h0000_0013;
    m_mis = 1'b0; m_cyc = 0; m_fc = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"},        pc,                 RPC);
    chk({tag, ".old_pc"},    old_pc,             RPC);
    chk({tag, ".pc_plus4"},  pc_plus4,           RPC + 32'd4);
    chk({tag, ".instr"},     instr,              32'h0000_0013);
    chk({tag, ".misalign"},  {31'b0, misalign_err}, 32'd0);
    chk({tag, ".cycle_cnt"}, {28'b0, cycle_cnt}, 32'd0);
    chk({tag, ".fetch_cnt"}, {28'b0, fetch_cnt}, 32'd0);
  endtask

  // Drive one cycle of inputs (caller is at a negedge), queue the expectation, compare after the edge.
  task automatic step(input logic we, upd, br, z, sel, input logic [31:0] ar, areg, mem,
                      input exp_t e);
    exp_t got;
    logic [31:0] ei;
    we_ir = we; pc_update = upd; branch = br; zero = z; sel_pc_src = sel;
    alu_result = ar; alu_reg = areg; mem_rdata = mem;
    sb.push_back(e);
    m_pc = e.pc; m_old = e.old; m_p4 = e.p4; m_instr = e.instr; m_mis = e.mis;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      ei  = got.instr;
      chk("pc",        pc,                    got.pc);
      chk("old_pc",    old_pc,                got.old);
      chk("pc_plus4",  pc_plus4,              got.p4);
      chk("instr",     instr,                 got.instr);
      chk("op",        {25'b0, op},           {25'b0, ei[6:0]});
      chk("misalign",  {31'b0, misalign_err}, {31'b0, got.mis});
      chk("cycle_cnt", {28'b0, cycle_cnt},    32'(got.cyc % 16));
      chk("fetch_cnt", {28'b0, fetch_cnt},    32'(got.fc % 16));
    end
    @(negedge clk);
  endtask

  // Independent behavioural prediction used for the random phase and the wrap run.
  task automatic model_step(input logic we, upd, br, z, sel, input logic [31:0] ar, areg, mem);
    exp_t e;
    logic [31:0] np;
    np = sel ? areg : ar;
    e.pc = m_pc; e.old = m_old; e.p4 = m_p4; e.instr = m_instr; e.mis = m_mis;
    if (upd && (!br || z)) begin
      e.pc = np & 32'hFFFF_FFFC;
      if (np[1:0] != 2'b00) e.mis = 1'b1;
    end
    if (we) begin
      e.instr = mem; e.old = m_pc; e.p4 = m_pc + 32'd4;
    end
    m_cyc++;
    if (we) m_fc++;
    e.cyc = m_cyc; e.fc = m_fc;
    step(we, upd, br, z, sel, ar, areg, mem, e);
  endtask

  initial begin
    //            we upd br z sel alu_result     alu_reg        mem_rdata      pc             old_pc         pc_plus4       instr          mis
    tbl[0]  = '{1, 1, 0, 0, 0, 32'h0000_0104, 32'h0000_0000, 32'h0050_0093, 32'h0000_0104, 32'h0000_0100, 32'h0000_0104, 32'h0050_0093, 0};
    tbl[1]  = '{0, 1, 1, 0, 1, 32'h0000_0003, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0000_0100, 32'h0000_0104, 32'h0050_0093, 0};
    tbl[2]  = '{0, 1, 1, 0, 1, 32'h0000_0000, 32'h0000_0202, 32'h0000_0000, 32'h0000_0104, 32'h0000_0100, 32'h0000_0104, 32'h0050_0093, 0};
    tbl[3]  = '{0, 1, 1, 1, 1, 32'h0000_0000, 32'h0000_0200, 32'h0000_0000, 32'h0000_0200, 32'h0000_0100, 32'h0000_0104, 32'h0050_0093, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 32'h0000_0999, 32'h0000_0777, 32'h0000_0000, 32'h0000_0200, 32'h0000_0100, 32'h0000_0104, 32'h0050_0093, 0};
    tbl[5]  = '{1, 1, 0, 0, 0, 32'h0000_0204, 32'h0000_0000, 32'h0020_8133, 32'h0000_0204, 32'h0000_0200, 32'h0000_0204, 32'h0020_8133, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_006F, 32'h0000_0204, 32'h0000_0204, 32'h0000_0208, 32'h0000_006F, 0};
    tbl[7]  = '{0, 1, 0, 0, 1, 32'h0000_0000, 32'h0000_0082, 32'h0000_0000, 32'h0000_0080, 32'h0000_0204, 32'h0000_0208, 32'h0000_006F, 1};
    tbl[8]  = '{0, 1, 0, 0, 0, 32'h0000_0300, 32'h0000_0000, 32'h0000_0000, 32'h0000_0300, 32'h0000_0204, 32'h0000_0208, 32'h0000_006F, 1};
    tbl[9]  = '{0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0204, 32'h0000_0208, 32'h0000_006F, 1};
    tbl[10] = '{1, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5637, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1234_5637, 1};
    tbl[11] = '{0, 1, 0, 1, 0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1234_5637, 1};

    rst = 1'b1;
    we_ir = 0; pc_update = 0; branch = 0; zero = 0; sel_pc_src = 0;
    alu_result = '0; alu_reg = '0; mem_rdata = '0;
    model_reset();
    #1;
    chk_reset("por");
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 12; i++) begin
      exp_t e;
      m_cyc++;
      if (tbl[i].we) m_fc++;
      e.pc = tbl[i].e_pc; e.old = tbl[i].e_old; e.p4 = tbl[i].e_p4;
      e.instr = tbl[i].e_instr; e.mis = tbl[i].e_mis; e.cyc = m_cyc; e.fc = m_fc;
      step(tbl[i].we, tbl[i].upd, tbl[i].br, tbl[i].z, tbl[i].sel,
           tbl[i].ar, tbl[i].areg, tbl[i].mem, e);
    end

    for (int unsigned i = 0; i < 40; i++) begin
      logic [31:0] ar, areg;
      ar   = $urandom;
      areg = $urandom;
      if ($urandom_range(3) != 0) ar[1:0] = 2'b00;
      model_step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ar, areg, $urandom);
    end

    // Asynchronous reset mid-cycle: outputs must change without any clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    we_ir = 1; pc_update = 1; branch = 0; sel_pc_src = 0;
    alu_result = 32'h0000_0444; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 chk_reset("rst_held");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int unsigned i = 0; i < 17; i++)
      model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_1000 + 32'(i));
    chk("wrap.cycle_cnt", {28'b0, cycle_cnt}, 32'd1);
    chk("wrap.fetch_cnt", {28'b0, fetch_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_ir_unit.md
PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: COUNT_W, default 32, width of cycle and fetch counters.
REQ-003 clk  input  1  single clock, all state rising-edge triggered.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 we_ir  input  1  capture instruction, old PC and PC+4.
REQ-006 pc_update  input  1  request PC write.
REQ-007 branch  input  1  PC write is conditional on zero.
REQ-008 zero  input  1  ALU zero flag.
REQ-009 sel_pc_src  input  1  next-PC select: 0 = alu_result, 1 = alu_reg.
REQ-010 alu_result  input  32  combinational ALU output.
REQ-011 alu_reg  input  32  ALU output registered in the previous cycle.
REQ-012 mem_rdata  input  32  instruction/data memory read data.
REQ-013 pc  output  32  current PC, drives the fetch address.
REQ-014 old_pc  output  32  PC of the instruction held in instr.
REQ-015 pc_plus4  output  32  old_pc + 4, registered.
REQ-016 instr  output  32  instruction register.
REQ-017 op  output  7  instr[6:0], combinational from instr.
REQ-018 misalign_err  output  1  sticky misaligned-target flag.
REQ-019 cycle_cnt  output  COUNT_W  free-running cycle counter.
REQ-020 fetch_cnt  output  COUNT_W  count of instruction captures.

Function
REQ-021 pc_we = pc_update AND (NOT branch OR zero); pc SHALL change only when pc_we = 1.
REQ-022 next_pc = alu_result when sel_pc_src = 0, alu_reg when sel_pc_src = 1; latency to pc output: one clock edge.
REQ-023 On pc_we, pc SHALL load {next_pc[31:2], 2'b00}; if next_pc[1:0] != 00, misalign_err SHALL set on the same edge and hold until reset.
REQ-024 On we_ir: instr <= mem_rdata, old_pc <= pc, pc_plus4 <= pc + 4 (dedicated adder, modulo 2^32), all on one edge.
REQ-025 we_ir and pc_we in the same cycle: instr, old_pc and pc_plus4 SHALL use the pre-edge pc; pc takes next_pc.
REQ-026 we_ir = 0: instr, old_pc and pc_plus4 SHALL hold.
REQ-027 branch = 1 and zero = 0 with pc_update = 1: pc holds; misalign_err not evaluated.
REQ-028 cycle_cnt SHALL increment every cycle out of reset, wrapping all-ones to 0.
REQ-029 fetch_cnt SHALL increment on each we_ir cycle, wrapping all-ones to 0.
REQ-030 Internal state: pc, old_pc, pc_plus4, instr, misalign_err, two counters; no state machine beyond these registers.

Reset
REQ-031 rst asserted at any time, including mid-instruction, SHALL immediately force pc = RESET_PC, old_pc = RESET_PC, pc_plus4 = RESET_PC + 4, instr = 32'h0000_0013 (NOP), misalign_err = 0, both counters = 0.
REQ-032 While rst is high, all inputs SHALL be ignored.
REQ-033 First edge after rst deasserts SHALL count as cycle 1.

Structure
REQ-034 NOP encoding and the 7-bit opcode constants SHALL live in a shared package, also used by the control FSM.
REQ-035 Counters SHALL be one sub-module, wrap_counter (parameter width, enable input), instantiated twice.
REQ-036 No memory or ALU instantiated inside; pc_plus4 adder is local.

Verification
REQ-037 Reset: rst pulse mid-run -> pc = RESET_PC, instr = 32'h0000_0013, counters 0, misalign_err 0 during reset, no clock required.
REQ-038 Fetch: pc = 0x100, mem_rdata = 0x00500093, we_ir = 1, pc_update = 1, sel_pc_src = 0, alu_result = 0x104 -> instr = 0x00500093, op = 0x13, old_pc = 0x100, pc_plus4 = 0x104, pc = 0x104, fetch_cnt +1.
REQ-039 Branch not taken: branch = 1, pc_update = 1, zero = 0, alu_reg = 0x200 -> pc unchanged. Taken: zero = 1 -> pc = 0x200.
REQ-040 Jump: sel_pc_src = 1, pc_update = 1, branch = 0, alu_reg = 0x0000_0082 -> pc = 0x80, misalign_err = 1 and stays 1 over later aligned writes.
REQ-041 Wrap: COUNT_W = 4, 17 cycles after reset -> cycle_cnt = 1; pc = 0xFFFF_FFFC fetch -> pc_plus4 = 0x0000_0000.
